pay_sequencer: RTL and testbench
================================

Name: pay_sequencer

Overview:
- Controls one purchase transaction for the vending datapath: start, coin accumulation, timeout, settlement, result display.
- Accumulates coin pulses against a latched BCD price and runs a per-second countdown.
- Computes the change or refund in BCD.
- Sequences the end-of-payment display through its enable, mode, returnone and returnten inputs, then returns idle.

Parameters:
TICK_DIV, 100000000, clk cycles per 1 s tick (set small in simulation)
PAY_TIMEOUT, 30, seconds allowed in PAY, range 1..99
SHOW_TIME, 6, seconds endpay_en is held high

Ports:
clk  input  1  system clock
EN  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begins transaction
price_ten  input  4  price tens digit, BCD
price_one  input  4  price ones digit, BCD
coin_one  input  1  one-cycle pulse, +1
coin_five  input  1  one-cycle pulse, +5
coin_ten  input  1  one-cycle pulse, +10
confirm  input  1  one-cycle pulse, request settlement
cancel  input  1  one-cycle pulse, abort with refund
busy  output  1  high in any state except IDLE
sec_left  output  7  remaining PAY seconds, binary
paid  output  7  accumulated amount, binary 0..99
endpay_en  output  1  display enable (active high)
endpay_mode  output  1  0 = success, 1 = fail
returnten  output  4  change tens digit, BCD
returnone  output  4  change ones digit, BCD
vend  output  1  one-cycle pulse on successful sale
done  output  1  one-cycle pulse at transaction end

Behaviour:
- Reset (EN low, asynchronous): state IDLE. All outputs 0. Tick divider 0. Latched price 0.
- Tick: divider counts 0..TICK_DIV-1 and generates a 1-cycle tick at wrap. Divider clears on every state entry.
- IDLE:
  - start with valid price moves to PAY.
  - Valid price: both digits <= 9 and value price_ten*10+price_one in 1..99.
  - On that transition: latch price, paid <= 0, sec_left <= PAY_TIMEOUT.
  - start with an invalid price is ignored; stay IDLE.
  - Coins, confirm and cancel are ignored.
- PAY:
  - Same-cycle coin pulses are summed (1+5+10 = 16 max) and added to paid. paid saturates at 99.
  - Decisions use paid as registered before this cycle. Same-cycle coins are still added.
  - Priority: cancel > confirm > timeout.
  - cancel → SETTLE with fail.
  - confirm with paid >= price → SETTLE with success. confirm with paid < price is ignored.
  - On tick, sec_left decrements. A tick with sec_left == 1 sets sec_left to 0 and goes to SETTLE with fail.
  - start is ignored.
- SETTLE (exactly 1 cycle):
  - change = paid - price on success; change = paid on fail.
  - returnten = change/10, returnone = change%10, registered here.
  - endpay_mode is set. Next state is SHOW.
- SHOW:
  - endpay_en = 1 throughout.
  - On entry, vend pulses for 1 cycle on success only.
  - After SHOW_TIME ticks → DONE. All inputs are ignored.
- DONE (1 cycle):
  - endpay_en = 0, done = 1.
  - paid, sec_left, returnten and returnone clear to 0. endpay_mode holds.
  - Next state is IDLE.
- Total latency: confirm accepted at cycle N gives endpay_en high from N+2. It falls at N+2+SHOW_TIME*TICK_DIV.
- Reset mid-operation: immediate return to IDLE, endpay_en low. This resets the display block. No vend or done pulse is issued.
- Arithmetic: paid and change are 7-bit unsigned. Change never exceeds 99. Digits are always valid BCD.

Optional Feature:
PAY_SEQUENCER_AUTO_CONFIRM_EN
- Defined: in PAY, when paid reaches >= price with no cancel in that cycle, the block enters SETTLE with success on the following cycle without needing confirm. confirm remains accepted.
- Undefined: success requires an explicit confirm.

Test Plan:
- TICK_DIV=10, PAY_TIMEOUT=5, SHOW_TIME=2. Price 2/3; coins ten, ten, five; confirm → paid=25, endpay_mode=0, returnten=0, returnone=2. vend pulse once. endpay_en high for exactly 20 cycles, then done pulse.
- Price 5/0; coin_ten once; confirm → ignored, stays PAY. cancel → endpay_mode=1, returnten=1, returnone=0, no vend.
- Price 0/9; coin_five; no further input → sec_left steps 5→0 on ticks. Fail with refund 0/5 after 50 cycles.
- Price 9/9; coin_one, coin_five and coin_ten all in one cycle, repeated 7 times → paid saturates at 99. confirm → change 0/0, success.
- Price 0/0, then price 1/A → start ignored, busy stays 0.
- Assert EN low during SHOW → endpay_en, busy and paid are 0 immediately. Next valid start runs normally.

Source files
------------

// File: rtl/pay_sequencer.sv
// pay_sequencer
//   Sequences a single vending purchase: start with a latched BCD price,
//   accumulate coin pulses, honour cancel/confirm/timeout, compute the
//   change or refund in BCD, hold the result display for SHOW_TIME seconds,
//   then report completion and return to idle.
//
// Optional build macro: PAY_SEQUENCER_AUTO_CONFIRM_EN
//   When defined, PAY settles with success automatically as soon as the
//   registered paid amount covers the price (cancel still wins).
//
// Ports
//   clk          system clock
//   EN           asynchronous active-low reset
//   start        1-cycle pulse, begins a transaction (needs a valid price)
//   price_ten    price tens digit, BCD
//   price_one    price ones digit, BCD
//   coin_one     1-cycle pulse, +1
//   coin_five    1-cycle pulse, +5
//   coin_ten     1-cycle pulse, +10
//   confirm      1-cycle pulse, request settlement
//   cancel       1-cycle pulse, abort with refund
//   busy         high outside IDLE
//   sec_left     remaining PAY seconds, binary
//   paid         accumulated amount, binary 0..99 (saturating)
//   endpay_en    result display enable
//   endpay_mode  0 = success, 1 = fail
//   returnten    change tens digit, BCD
//   returnone    change ones digit, BCD
//   vend         1-cycle pulse on successful sale (first SHOW cycle)
//   done         1-cycle pulse at transaction end (DONE state)
module pay_sequencer #(
  parameter int TICK_DIV    = 100000000,
  parameter int PAY_TIMEOUT = 30,
  parameter int SHOW_TIME   = 6
) (
  input  logic       clk,
  input  logic       EN,
  input  logic       start,
  input  logic [3:0] price_ten,
  input  logic [3:0] price_one,
  input  logic       coin_one,
  input  logic       coin_five,
  input  logic       coin_ten,
  input  logic       confirm,
  input  logic       cancel,
  output logic       busy,
  output logic [6:0] sec_left,
  output logic [6:0] paid,
  output logic       endpay_en,
  output logic       endpay_mode,
  output logic [3:0] returnten,
  output logic [3:0] returnone,
  output logic       vend,
  output logic       done
);

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SHOW_W = $clog2(SHOW_TIME + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_TIME - 1);
  localparam logic [6:0]        TIMEOUT_INIT = 7'(PAY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAY,
    S_SETTLE,
    S_SHOW,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [SHOW_W-1:0] r_show_cnt;
  logic [6:0]        r_price;
  logic [6:0]        r_paid;
  logic [6:0]        r_sec_left;
  logic              r_fail;
  logic              r_busy;
  logic              r_endpay_en;
  logic              r_endpay_mode;
  logic [3:0]        r_returnten;
  logic [3:0]        r_returnone;
  logic              r_vend;
  logic              r_done;

  logic              w_tick;
  logic [6:0]        w_price_in;
  logic              w_price_ok;
  logic [4:0]        w_coin_sum;
  logic [7:0]        w_paid_raw;
  logic [6:0]        w_paid_sat;
  logic              w_enough;
  logic              w_auto;
  logic              w_accept;
  logic [6:0]        w_change;
  logic [3:0]        w_ten;
  logic [3:0]        w_one;

  // One-second tick: last count of the divider, which restarts on every
  // state entry so each state sees whole seconds from its first cycle.
  assign w_tick = (r_div == DIV_LAST);

  // Price is only usable when both digits are BCD and the value is 1..99.
  assign w_price_in = ({3'b000, price_ten} * 7'd10) + {3'b000, price_one};
  assign w_price_ok = (price_ten <= 4'd9) && (price_one <= 4'd9) &&
                      (w_price_in != 7'd0);

  // All coin pulses of one cycle are summed, then paid saturates at 99.
  assign w_coin_sum = {4'b0000, coin_one} +
                      (coin_five ? 5'd5 : 5'd0) +
                      (coin_ten  ? 5'd10 : 5'd0);
  assign w_paid_raw = {1'b0, r_paid} + {3'b000, w_coin_sum};
  assign w_paid_sat = (w_paid_raw > 8'd99) ? 7'd99 : w_paid_raw[6:0];

  // Settlement decisions look at paid as registered before this cycle.
  assign w_enough = (r_paid >= r_price);

`ifdef PAY_SEQUENCER_AUTO_CONFIRM_EN
  assign w_auto = 1'b1;
`else
  assign w_auto = 1'b0;
`endif

  assign w_accept = (confirm | w_auto) & w_enough;

  // Refund the whole amount on fail, the excess on success.
  assign w_change = r_fail ? r_paid : (r_paid - r_price);
  assign w_ten    = 4'(w_change / 7'd10);
  assign w_one    = 4'(w_change % 7'd10);

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_show_cnt    <= '0;
      r_price       <= '0;
      r_paid        <= '0;
      r_sec_left    <= '0;
      r_fail        <= 1'b0;
      r_busy        <= 1'b0;
      r_endpay_en   <= 1'b0;
      r_endpay_mode <= 1'b0;
      r_returnten   <= '0;
      r_returnone   <= '0;
      r_vend        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_vend <= 1'b0;
      r_done <= 1'b0;
      r_div  <= w_tick ? '0 : (r_div + DIV_W'(1));

      case (r_state)
        S_IDLE: begin
          if (start && w_price_ok) begin
            r_price    <= w_price_in;
            r_paid     <= '0;
            r_sec_left <= TIMEOUT_INIT;
            r_busy     <= 1'b1;
            r_div      <= '0;
            r_state    <= S_PAY;
          end
        end

        S_PAY: begin
          r_paid <= w_paid_sat;
          if (w_tick) begin
            r_sec_left <= r_sec_left - 7'd1;
          end
          if (cancel) begin
            r_fail  <= 1'b1;
            r_div   <= '0;
            r_state <= S_SETTLE;
          end else if (w_accept) begin
            r_fail  <= 1'b0;
            r_div   <= '0;
            r_state <= S_SETTLE;
          end else if (w_tick && (r_sec_left == 7'd1)) begin
            r_fail  <= 1'b1;
            r_div   <= '0;
            r_state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          r_returnten   <= w_ten;
          r_returnone   <= w_one;
          r_endpay_mode <= r_fail;
          r_endpay_en   <= 1'b1;
          r_vend        <= ~r_fail;
          r_show_cnt    <= '0;
          r_div         <= '0;
          r_state       <= S_SHOW;
        end

        S_SHOW: begin
          if (w_tick) begin
            if (r_show_cnt == SHOW_LAST) begin
              r_endpay_en <= 1'b0;
              r_done      <= 1'b1;
              r_paid      <= '0;
              r_sec_left  <= '0;
              r_returnten <= '0;
              r_returnone <= '0;
              r_div       <= '0;
              r_state     <= S_DONE;
            end else begin
              r_show_cnt <= r_show_cnt + SHOW_W'(1);
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_div   <= '0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign sec_left    = r_sec_left;
  assign paid        = r_paid;
  assign endpay_en   = r_endpay_en;
  assign endpay_mode = r_endpay_mode;
  assign returnten   = r_returnten;
  assign returnone   = r_returnone;
  assign vend        = r_vend;
  assign done        = r_done;

endmodule

// File: tb/tb_pay_sequencer.sv
// Self-checking bench for pay_sequencer with small timing parameters.
module tb_pay_sequencer;

  localparam int TICK  = 10;
  localparam int PT    = 5;
  localparam int SHOWT = 2;
`ifdef PAY_SEQUENCER_AUTO_CONFIRM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       EN = 1'b1;
  logic       start = 1'b0;
  logic [3:0] price_ten = 4'd0;
  logic [3:0] price_one = 4'd0;
  logic       coin_one = 1'b0;
  logic       coin_five = 1'b0;
  logic       coin_ten = 1'b0;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic       busy;
  logic [6:0] sec_left;
  logic [6:0] paid;
  logic       endpay_en;
  logic       endpay_mode;
  logic [3:0] returnten;
  logic [3:0] returnone;
  logic       vend;
  logic       done;

  pay_sequencer #(
    .TICK_DIV(TICK),
    .PAY_TIMEOUT(PT),
    .SHOW_TIME(SHOWT)
  ) dut (
    .clk(clk),
    .EN(EN),
    .start(start),
    .price_ten(price_ten),
    .price_one(price_one),
    .coin_one(coin_one),
    .coin_five(coin_five),
    .coin_ten(coin_ten),
    .confirm(confirm),
    .cancel(cancel),
    .busy(busy),
    .sec_left(sec_left),
    .paid(paid),
    .endpay_en(endpay_en),
    .endpay_mode(endpay_mode),
    .returnten(returnten),
    .returnone(returnone),
    .vend(vend),
    .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Phases: 0 idle, 1 paying, 2 settling, 3 showing, 4 finishing.
  // Time inside a phase is tracked as a plain cycle count; seconds are
  // derived arithmetically from it.
  int m_phase = 0, m_price = 0, m_paid = 0, m_sec = 0, m_cyc = 0;
  int m_show_left = 0, m_fail = 0, m_rt = 0, m_ro = 0, m_mode = 0, m_vend = 0;
  int m_old, m_coins, m_change;
  bit m_tick, m_enough;

  always @(posedge clk or negedge EN) begin
    if (!EN) begin
      m_phase = 0; m_price = 0; m_paid = 0; m_sec = 0; m_cyc = 0;
      m_show_left = 0; m_fail = 0; m_rt = 0; m_ro = 0; m_mode = 0; m_vend = 0;
    end else begin
      m_vend = 0;
      case (m_phase)
        0: begin
          if (start && price_ten <= 9 && price_one <= 9 &&
              (int'(price_ten) * 10 + int'(price_one)) >= 1) begin
            m_price = int'(price_ten) * 10 + int'(price_one);
            m_paid = 0;
            m_sec = PT;
            m_cyc = 0;
            m_phase = 1;
          end
        end
        1: begin
          m_old = m_paid;
          m_enough = (m_old >= m_price);
          m_coins = (coin_one ? 1 : 0) + (coin_five ? 5 : 0) + (coin_ten ? 10 : 0);
          m_paid = (m_old + m_coins > 99) ? 99 : m_old + m_coins;
          m_tick = ((m_cyc % TICK) == TICK - 1);
          m_cyc++;
          if (m_tick) m_sec--;
          if (cancel) begin
            m_fail = 1; m_phase = 2;
          end else if ((confirm || AUTO) && m_enough) begin
            m_fail = 0; m_phase = 2;
          end else if (m_tick && m_sec == 0) begin
            m_fail = 1; m_phase = 2;
          end
        end
        2: begin
          m_change = m_fail ? m_paid : m_paid - m_price;
          m_rt = m_change / 10;
          m_ro = m_change % 10;
          m_mode = m_fail;
          m_vend = m_fail ? 0 : 1;
          m_show_left = SHOWT * TICK;
          m_phase = 3;
        end
        3: begin
          m_show_left--;
          if (m_show_left == 0) begin
            m_paid = 0; m_sec = 0; m_rt = 0; m_ro = 0;
            m_phase = 4;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Single compare process: every output, every cycle.
  always @(negedge clk) begin
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("sec_left", sec_left, m_sec);
    chk("paid", paid, m_paid);
    chk("endpay_en", endpay_en, (m_phase == 3) ? 1 : 0);
    chk("endpay_mode", endpay_mode, m_mode);
    chk("returnten", returnten, m_rt);
    chk("returnone", returnone, m_ro);
    chk("vend", vend, m_vend);
    chk("done", done, (m_phase == 4) ? 1 : 0);
  end

  // ---------------- event monitor for literal checks ----------------
  int vend_cnt = 0, done_cnt = 0, en_cnt = 0, pre_cnt = 0;
  int cap_mode = -1, cap_rt = -1, cap_ro = -1, cap_paid = -1, cap_sec = -1;
  bit prev_en = 1'b0;

  always @(negedge clk) begin
    if (vend) vend_cnt++;
    if (done) done_cnt++;
    if (endpay_en) en_cnt++;
    if (busy && !endpay_en && !done) pre_cnt++;
    if (endpay_en && !prev_en) begin
      cap_mode = endpay_mode;
      cap_rt = returnten;
      cap_ro = returnone;
      cap_paid = paid;
      cap_sec = sec_left;
    end
    prev_en = endpay_en;
  end

  // Called only at a negedge while idle, so the monitor is not counting.
  task automatic clr_counts();
    vend_cnt = 0; done_cnt = 0; en_cnt = 0; pre_cnt = 0;
    cap_mode = -1; cap_rt = -1; cap_ro = -1; cap_paid = -1; cap_sec = -1;
  endtask

  task automatic do_start(input logic [3:0] t, input logic [3:0] o);
    price_ten = t;
    price_one = o;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse(input bit c1, input bit c5, input bit c10, input bit cf, input bit cn);
    coin_one = c1; coin_five = c5; coin_ten = c10; confirm = cf; cancel = cn;
    @(negedge clk);
    coin_one = 0; coin_five = 0; coin_ten = 0; confirm = 0; cancel = 0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    chk({nm, "_idle_timeout"}, busy, 0);
  endtask

  task automatic wait_en(input int budget, input string nm);
    int n;
    n = 0;
    while (!endpay_en && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_show_timeout"}, endpay_en, 1);
  endtask

  task automatic txn_line(input int id);
    $display("txn %0d: mode=%0d change=%0d%0d paid=%0d vend=%0d done=%0d en_cycles=%0d pre_cycles=%0d",
             id, cap_mode, cap_rt, cap_ro, cap_paid, vend_cnt, done_cnt, en_cnt, pre_cnt);
  endtask

  initial begin
    #1 EN = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_endpay_en", endpay_en, 0);
    chk("rst_paid", paid, 0);
    chk("rst_returnone", returnone, 0);
    EN = 1'b1;
    @(negedge clk);

    // 1: price 23, pay 10+10+5, confirm -> change 02, success
    clr_counts();
    do_start(4'd2, 4'd3);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    wait_idle(200, "t1");
    chk("t1_mode", cap_mode, 0);
    chk("t1_rt", cap_rt, 0);
    chk("t1_ro", cap_ro, 2);
    chk("t1_paid", cap_paid, 25);
    chk("t1_vend_cnt", vend_cnt, 1);
    chk("t1_en_cycles", en_cnt, 20);
    chk("t1_done_cnt", done_cnt, 1);
    txn_line(1);

    // 2: price 50, pay 10, confirm ignored, cancel -> refund 10
    clr_counts();
    do_start(4'd5, 4'd0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk("t2_still_busy", busy, 1);
    chk("t2_no_show", endpay_en, 0);
    chk("t2_paid", paid, 10);
    pulse(0, 0, 0, 0, 1);
    wait_idle(200, "t2");
    chk("t2_mode", cap_mode, 1);
    chk("t2_rt", cap_rt, 1);
    chk("t2_ro", cap_ro, 0);
    chk("t2_vend_cnt", vend_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);
    txn_line(2);

    // 3: price 09, pay 5, timeout -> refund 05 after 50 PAY cycles
    clr_counts();
    do_start(4'd0, 4'd9);
    pulse(0, 1, 0, 0, 0);
    wait_idle(300, "t3");
    chk("t3_pre_cycles", pre_cnt, 51);
    chk("t3_sec_at_show", cap_sec, 0);
    chk("t3_mode", cap_mode, 1);
    chk("t3_rt", cap_rt, 0);
    chk("t3_ro", cap_ro, 5);
    chk("t3_vend_cnt", vend_cnt, 0);
    txn_line(3);

    // 4: price 99, 7 cycles of 1+5+10 -> saturate 99, confirm -> change 00
    clr_counts();
    do_start(4'd9, 4'd9);
    coin_one = 1; coin_five = 1; coin_ten = 1;
    repeat (7) @(negedge clk);
    coin_one = 0; coin_five = 0; coin_ten = 0;
    pulse(0, 0, 0, 1, 0);
    wait_idle(200, "t4");
    chk("t4_paid", cap_paid, 99);
    chk("t4_mode", cap_mode, 0);
    chk("t4_rt", cap_rt, 0);
    chk("t4_ro", cap_ro, 0);
    chk("t4_vend_cnt", vend_cnt, 1);
    txn_line(4);

    // 5: invalid prices 00 and 1A are ignored
    clr_counts();
    do_start(4'd0, 4'd0);
    repeat (2) @(negedge clk);
    chk("t5_busy_00", busy, 0);
    do_start(4'd1, 4'd10);
    repeat (2) @(negedge clk);
    chk("t5_busy_1A", busy, 0);
    chk("t5_pre_cycles", pre_cnt, 0);
    txn_line(5);

    // 6: reset during SHOW, then a normal transaction
    clr_counts();
    do_start(4'd2, 4'd3);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 1, 0, 0);
    pulse(0, 0, 0, 1, 0);
    wait_en(20, "t6");
    repeat (5) @(negedge clk);
    #2 EN = 1'b0;
    #1;
    chk("t6_rst_en", endpay_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_paid", paid, 0);
    @(negedge clk);
    EN = 1'b1;
    @(negedge clk);
    chk("t6_done_cnt", done_cnt, 0);
    txn_line(6);
    clr_counts();
    do_start(4'd0, 4'd1);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    wait_idle(200, "t6b");
    chk("t6b_mode", cap_mode, 0);
    chk("t6b_ro", cap_ro, 0);
    chk("t6b_paid", cap_paid, 1);
    chk("t6b_vend_cnt", vend_cnt, 1);
    chk("t6b_done_cnt", done_cnt, 1);
    chk("t6b_en_cycles", en_cnt, 20);
    txn_line(7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
